// File: rtl/pet_state_ctrl.sv
// pet_state_ctrl
//   Core game-state stage of the virtual pet. It takes the debounced button
//   levels, turns each rising edge into a one-cycle event, runs a tick time
//   base, decays hunger and health over time, and derives the pet condition
//   and the display selection. Every output is a register.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   feeding      debounced feed button level
//   healing      debounced heal button level
//   change       debounced display-change button level
//   testBut      conditioned test-mode button level
//   hunger       fullness level, 0..MAX_LEVEL
//   health       health level, 0..MAX_LEVEL
//   pet_state    0=OK, 1=HUNGRY, 2=SICK, 3=DEAD
//   disp_sel     0=hunger, 1=health, 2=state
//   test_active  test mode flag (short tick period)
//   tick         one-cycle pulse per time-base tick
module pet_state_ctrl #(
  parameter int unsigned TICK_CYCLES      = 50000000,
  parameter int unsigned TEST_TICK_CYCLES = 50000,
  parameter int unsigned HUNGER_DECAY     = 10,
  parameter int unsigned HEALTH_DECAY     = 20,
  parameter int unsigned MAX_LEVEL        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       feeding,
  input  logic       healing,
  input  logic       change,
  input  logic       testBut,
  output logic [2:0] hunger,
  output logic [2:0] health,
  output logic [1:0] pet_state,
  output logic [1:0] disp_sel,
  output logic       test_active,
  output logic       tick
);

  localparam int unsigned CNT_MAX = (TICK_CYCLES > TEST_TICK_CYCLES) ? TICK_CYCLES : TEST_TICK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned HT_W    = $clog2(HUNGER_DECAY + 1);
  localparam int unsigned LT_W    = $clog2(HEALTH_DECAY + 1);

  localparam logic [CNT_W-1:0] NORM_LAST   = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] TEST_LAST   = CNT_W'(TEST_TICK_CYCLES - 1);
  localparam logic [HT_W-1:0]  HUNGER_LAST = HT_W'(HUNGER_DECAY - 1);
  localparam logic [LT_W-1:0]  HEALTH_LAST = LT_W'(HEALTH_DECAY - 1);
  localparam logic [2:0]       MAX_LVL     = 3'(MAX_LEVEL);

  typedef enum logic [1:0] {
    PET_OK     = 2'd0,
    PET_HUNGRY = 2'd1,
    PET_SICK   = 2'd2,
    PET_DEAD   = 2'd3
  } pet_state_t;

  typedef enum logic [1:0] {
    DISP_HUNGER = 2'd0,
    DISP_HEALTH = 2'd1,
    DISP_STATE  = 2'd2
  } disp_sel_t;

  // registered state
  logic             feed_prev, heal_prev, change_prev, test_prev;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [HT_W-1:0]  hunger_tmr_q;
  logic [LT_W-1:0]  health_tmr_q;
  logic [2:0]       hunger_q, health_q;
  pet_state_t       pet_state_q;
  disp_sel_t        disp_sel_q;
  logic             test_active_q, tick_q;

  // next-state values
  logic             ev_feed, ev_heal, ev_change, ev_test;
  logic             is_dead;
  logic             test_next;
  logic [CNT_W-1:0] period_last, next_last, tick_cnt_next;
  logic             tick_next;
  logic             hunger_dec, health_dec;
  logic [HT_W-1:0]  hunger_tmr_next;
  logic [LT_W-1:0]  health_tmr_next;
  logic [2:0]       hunger_next, health_next;
  pet_state_t       pet_state_next;
  disp_sel_t        disp_sel_next;

  // Saturating +1/-1; an increment and a decrement together cancel.
  function automatic logic [2:0] step_level(input logic [2:0] cur,
                                            input logic       inc,
                                            input logic       dec);
    logic [2:0] res;
    res = cur;
    if (inc && !dec && cur != MAX_LVL)
      res = cur + 3'd1;
    else if (dec && !inc && cur != 3'd0)
      res = cur - 3'd1;
    return res;
  endfunction

  always_comb begin
    ev_feed   = feeding & ~feed_prev;
    ev_heal   = healing & ~heal_prev;
    ev_change = change  & ~change_prev;
    ev_test   = testBut & ~test_prev;

    // health==0 is checked directly rather than via pet_state so that a heal
    // arriving in the cycle before pet_state catches up cannot revive the pet.
    is_dead = (health_q == 3'd0);

    // Time base. tick is registered against the next count and next period
    // so it is high exactly in the cycle whose count equals P-1.
    test_next   = test_active_q ^ ev_test;
    period_last = test_active_q ? TEST_LAST : NORM_LAST;
    next_last   = test_next     ? TEST_LAST : NORM_LAST;
    if (ev_test || tick_cnt_q >= period_last)
      tick_cnt_next = '0;
    else
      tick_cnt_next = tick_cnt_q + CNT_W'(1);
    tick_next = (tick_cnt_next == next_last);

    // Hunger decay timer
    hunger_dec      = 1'b0;
    hunger_tmr_next = hunger_tmr_q;
    if (!is_dead && tick_q) begin
      if (hunger_tmr_q == HUNGER_LAST) begin
        hunger_tmr_next = '0;
        hunger_dec      = 1'b1;
      end else begin
        hunger_tmr_next = hunger_tmr_q + HT_W'(1);
      end
    end

    // Health decay timer; starving pets lose health on every tick
    health_dec      = 1'b0;
    health_tmr_next = health_tmr_q;
    if (!is_dead) begin
      if (hunger_q == 3'd0) begin
        health_tmr_next = '0;
        health_dec      = tick_q;
      end else if (tick_q) begin
        if (health_tmr_q == HEALTH_LAST) begin
          health_tmr_next = '0;
          health_dec      = 1'b1;
        end else begin
          health_tmr_next = health_tmr_q + LT_W'(1);
        end
      end
    end

    hunger_next = step_level(hunger_q, ev_feed && !is_dead, hunger_dec);
    health_next = step_level(health_q, ev_heal && !is_dead, health_dec);

    if (health_q == 3'd0)
      pet_state_next = PET_DEAD;
    else if (health_q <= 3'd1)
      pet_state_next = PET_SICK;
    else if (hunger_q <= 3'd1)
      pet_state_next = PET_HUNGRY;
    else
      pet_state_next = PET_OK;

    disp_sel_next = disp_sel_q;
    if (ev_change) begin
      case (disp_sel_q)
        DISP_HUNGER: disp_sel_next = DISP_HEALTH;
        DISP_HEALTH: disp_sel_next = DISP_STATE;
        default:     disp_sel_next = DISP_HUNGER;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // History starts high so a button held through reset gives no event
      feed_prev     <= 1'b1;
      heal_prev     <= 1'b1;
      change_prev   <= 1'b1;
      test_prev     <= 1'b1;
      tick_cnt_q    <= '0;
      hunger_tmr_q  <= '0;
      health_tmr_q  <= '0;
      hunger_q      <= MAX_LVL;
      health_q      <= MAX_LVL;
      pet_state_q   <= PET_OK;
      disp_sel_q    <= DISP_HUNGER;
      test_active_q <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      feed_prev     <= feeding;
      heal_prev     <= healing;
      change_prev   <= change;
      test_prev     <= testBut;
      tick_cnt_q    <= tick_cnt_next;
      hunger_tmr_q  <= hunger_tmr_next;
      health_tmr_q  <= health_tmr_next;
      hunger_q      <= hunger_next;
      health_q      <= health_next;
      pet_state_q   <= pet_state_next;
      disp_sel_q    <= disp_sel_next;
      test_active_q <= test_next;
      tick_q        <= tick_next;
    end
  end

  assign hunger      = hunger_q;
  assign health      = health_q;
  assign pet_state   = pet_state_q;
  assign disp_sel    = disp_sel_q;
  assign test_active = test_active_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_pet_state_ctrl.sv
// Testbench for pet_state_ctrl with small time constants.
module tb_pet_state_ctrl;

  localparam int TC  = 10;
  localparam int TT  = 2;
  localparam int HD  = 3;
  localparam int LD  = 5;
  localparam int MAX = 5;

  logic       clk, rst;
  logic       feeding, healing, change, testBut;
  logic [2:0] hunger, health;
  logic [1:0] pet_state, disp_sel;
  logic       test_active, tick;

  pet_state_ctrl #(
    .TICK_CYCLES(TC),
    .TEST_TICK_CYCLES(TT),
    .HUNGER_DECAY(HD),
    .HEALTH_DECAY(LD),
    .MAX_LEVEL(MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .feeding(feeding),
    .healing(healing),
    .change(change),
    .testBut(testBut),
    .hunger(hunger),
    .health(health),
    .pet_state(pet_state),
    .disp_sel(disp_sel),
    .test_active(test_active),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_hunger, m_health, m_state, m_disp, m_test, m_tick;
  int m_since;      // cycles since the current tick period started
  int m_hcnt, m_lcnt; // ticks counted toward the next decay
  bit pf, ph, pc, pt;

  function automatic int clampl(input int v);
    return (v < 0) ? 0 : (v > MAX) ? MAX : v;
  endfunction

  function automatic void model_reset();
    m_hunger = MAX; m_health = MAX; m_state = 0; m_disp = 0; m_test = 0; m_tick = 0;
    m_since = 0; m_hcnt = 0; m_lcnt = 0;
    pf = 1; ph = 1; pc = 1; pt = 1;
  endfunction

  function automatic void model_step(input bit f, input bit h, input bit c, input bit t);
    bit ef, eh, ec, et, dead;
    int hdec, ldec, ns, p;
    ef = f & !pf; eh = h & !ph; ec = c & !pc; et = t & !pt;
    pf = f; ph = h; pc = c; pt = t;
    dead = (m_health == 0);
    hdec = 0; ldec = 0;
    if (!dead && m_tick != 0) begin
      m_hcnt++;
      if (m_hcnt == HD) begin hdec = 1; m_hcnt = 0; end
    end
    if (!dead) begin
      if (m_hunger == 0) begin
        ldec = m_tick; m_lcnt = 0;
      end else if (m_tick != 0) begin
        m_lcnt++;
        if (m_lcnt == LD) begin ldec = 1; m_lcnt = 0; end
      end
    end
    ns = (m_health == 0) ? 3 : (m_health <= 1) ? 2 : (m_hunger <= 1) ? 1 : 0;
    if (!dead) begin
      m_hunger = clampl(m_hunger + int'(ef) - hdec);
      m_health = clampl(m_health + int'(eh) - ldec);
    end
    m_state = ns;
    if (ec) m_disp = (m_disp + 1) % 3;
    if (et) begin m_test = 1 - m_test; m_since = 0; end
    else m_since++;
    p = (m_test != 0) ? TT : TC;
    m_tick = ((m_since % p) == p - 1) ? 1 : 0;
  endfunction

  // One clock cycle: drive inputs, compare against the model mid-cycle,
  // advance the model, finish #1 after the next rising edge.
  logic seen_tick;
  task automatic do_cycle(input bit f, input bit h, input bit c, input bit t);
    feeding = f; healing = h; change = c; testBut = t;
    @(negedge clk);
    chk("hunger", hunger, m_hunger);
    chk("health", health, m_health);
    chk("pet_state", pet_state, m_state);
    chk("disp_sel", disp_sel, m_disp);
    chk("test_active", test_active, m_test);
    chk("tick", tick, m_tick);
    seen_tick = tick;
    model_step(f, h, c, t);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hunger"}, hunger, MAX);
    chk({tag, "_health"}, health, MAX);
    chk({tag, "_state"}, pet_state, 0);
    chk({tag, "_disp"}, disp_sel, 0);
    chk({tag, "_test"}, test_active, 0);
    chk({tag, "_tick"}, tick, 0);
  endtask

  // Mid-cycle async reset, checked before any clock edge, released #1 after the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1 chk_reset_vals(tag);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit f, h, c, t;
    int n;
    int e_hunger, e_health, e_state, e_disp, e_test;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int trans[$];
    int prev_st, incs, prev_h;
    bit rf, rh, rc, rt;

    vecs[0] = '{f:0, h:0, c:1, t:0, n:1, e_hunger:4, e_health:5, e_state:0, e_disp:1, e_test:0};
    vecs[1] = '{f:0, h:0, c:0, t:0, n:1, e_hunger:4, e_health:5, e_state:0, e_disp:1, e_test:0};
    vecs[2] = '{f:1, h:1, c:1, t:0, n:3, e_hunger:5, e_health:5, e_state:0, e_disp:2, e_test:0};
    vecs[3] = '{f:0, h:0, c:0, t:0, n:1, e_hunger:5, e_health:5, e_state:0, e_disp:2, e_test:0};
    vecs[4] = '{f:0, h:0, c:1, t:0, n:1, e_hunger:5, e_health:5, e_state:0, e_disp:0, e_test:0};
    vecs[5] = '{f:0, h:0, c:0, t:1, n:1, e_hunger:5, e_health:5, e_state:0, e_disp:0, e_test:1};
    vecs[6] = '{f:0, h:0, c:0, t:0, n:6, e_hunger:4, e_health:4, e_state:0, e_disp:0, e_test:1};

    rst = 1'b0; feeding = 0; healing = 0; change = 0; testBut = 0;
    model_reset();
    #12 chk_reset_vals("por");
    @(posedge clk);
    #1 rst = 1'b1;

    // Idle after reset: ticks at cycles 9, 19, 29; first hunger decay on 3rd tick
    for (int i = 0; i < 31; i++) begin
      do_cycle(0, 0, 0, 0);
      chk("tick_pos", seen_tick, (i == 9 || i == 19 || i == 29) ? 1 : 0);
    end
    chk("idle_hunger", hunger, 4);
    chk("idle_health", health, 5);
    chk("idle_state", pet_state, 0);

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vecs[v].n; k++)
        do_cycle(vecs[v].f, vecs[v].h, vecs[v].c, vecs[v].t);
      chk($sformatf("vec%0d_hunger", v), hunger, vecs[v].e_hunger);
      chk($sformatf("vec%0d_health", v), health, vecs[v].e_health);
      chk($sformatf("vec%0d_state", v), pet_state, vecs[v].e_state);
      chk($sformatf("vec%0d_disp", v), disp_sel, vecs[v].e_disp);
      chk($sformatf("vec%0d_test", v), test_active, vecs[v].e_test);
    end

    // Starve in test mode: OK -> HUNGRY -> SICK -> DEAD
    prev_st = pet_state;
    for (int i = 0; i < 400 && pet_state != 2'd3; i++) begin
      do_cycle(0, 0, 0, 0);
      if (pet_state != prev_st) begin
        trans.push_back(int'(pet_state));
        prev_st = pet_state;
      end
    end
    chk("dead_reached", pet_state, 3);
    chk("dead_trans_count", trans.size(), 3);
    for (int i = 0; i < trans.size() && i < 3; i++)
      chk($sformatf("dead_trans%0d", i), trans[i], i + 1);

    // DEAD ignores feed/heal, change and test still work
    do_cycle(1, 0, 0, 0); do_cycle(0, 0, 0, 0);
    do_cycle(0, 1, 0, 0); do_cycle(0, 0, 0, 0);
    chk("dead_hunger", hunger, 0);
    chk("dead_health", health, 0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(0, 0, 1, 0);
      chk($sformatf("dead_disp%0d", i), disp_sel, (i + 1) % 3);
      do_cycle(0, 0, 0, 0);
    end
    do_cycle(0, 0, 0, 1);
    chk("dead_test_toggle", test_active, 0);
    for (int i = 0; i < 25; i++) do_cycle(0, 0, 0, 0);
    chk("dead_hold_state", pet_state, 3);
    chk("dead_hold_health", health, 0);

    // Feed event coinciding with hunger decay at cycle 89 (hunger 3)
    async_reset("rst_mid");
    for (int i = 0; i < 89; i++) do_cycle(0, 0, 0, 0);
    chk("coll_pre", hunger, 3);
    do_cycle(1, 0, 0, 0);
    chk("coll_post", hunger, 3);
    do_cycle(0, 0, 0, 0);

    // Feed held 50 cycles: one increment only (one decay at cycle 119)
    incs = 0; prev_h = hunger;
    for (int i = 0; i < 50; i++) begin
      do_cycle(1, 0, 0, 0);
      if (i == 0) chk("hold_first", hunger, 4);
      if (int'(hunger) > prev_h) incs++;
      prev_h = hunger;
    end
    chk("hold_incs", incs, 1);
    chk("hold_end", hunger, 3);

    // Feed up to max and once more at max
    do_cycle(0, 0, 0, 0); do_cycle(1, 0, 0, 0);
    chk("feed_to4", hunger, 4);
    do_cycle(0, 0, 0, 0); do_cycle(1, 0, 0, 0);
    chk("feed_to5", hunger, 5);
    do_cycle(0, 0, 0, 0); do_cycle(1, 0, 0, 0);
    chk("feed_at_max", hunger, 5);

    // Reset with feeding/change held: no events until they fall and rise
    feeding = 1; change = 1;
    async_reset("rst_held");
    for (int i = 0; i < 35; i++) do_cycle(1, 0, 1, 0);
    chk("held_hunger", hunger, 4);
    chk("held_disp", disp_sel, 0);
    do_cycle(0, 0, 0, 0);
    do_cycle(1, 0, 1, 0);
    chk("rearm_hunger", hunger, 5);
    chk("rearm_disp", disp_sel, 1);

    // Random episodes against the model
    for (int ep = 0; ep < 6; ep++) begin
      async_reset($sformatf("rst_ep%0d", ep));
      rf = 0; rh = 0; rc = 0; rt = 0;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 7) == 0) rf = !rf;
        if ($urandom_range(0, (ep % 2 == 0) ? 5 : 39) == 0) rh = !rh;
        if ($urandom_range(0, 4) == 0) rc = !rc;
        if ($urandom_range(0, 79) == 0) rt = !rt;
        do_cycle(rf, rh, rc, rt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
